// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, busy-bit scoreboard with RAW/WAW stall,
// and a one-entry output register. Optional stall counter enabled by DECODE_STALL_COUNT_EN.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_we,
  output logic            out_illegal,
  output logic [31:0]     stall_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic        dec_writes;
  logic        dec_we;
  logic        dec_illegal;
  logic [31:0] dec_imm;

  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        hazard;
  logic        accept;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  assign A1 = rs1;
  assign A2 = rs2;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    dec_rs1_used = 1'b0;
    dec_rs2_used = 1'b0;
    dec_writes   = 1'b0;
    dec_illegal  = 1'b0;
    dec_imm      = 32'd0;
    case (opcode)
      OP_R: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_writes   = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        dec_rs1_used = 1'b1;
        dec_writes   = 1'b1;
        dec_imm      = imm_i;
      end
      OP_STORE: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_imm      = imm_s;
      end
      OP_BRANCH: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_imm      = imm_b;
      end
      OP_JAL: begin
        dec_writes = 1'b1;
        dec_imm    = imm_j;
      end
      OP_LUI, OP_AUIPC: begin
        dec_writes = 1'b1;
        dec_imm    = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // x0 is never tracked, so a write to it neither sets a busy bit nor counts as a write.
  assign dec_we = dec_writes & (rd != 5'd0);

  // The hazard looks at the registered busy vector only; a retire this cycle is seen next cycle.
  assign hazard = (dec_rs1_used & busy[rs1]) |
                  (dec_rs2_used & busy[rs2]) |
                  (dec_we & busy[rd]);

  // Handshake: a beat moves on a port in any cycle where its valid and ready are both high.
  // in_ready never depends on in_valid; out_* are held stable while out_valid & !out_ready.
  assign in_ready = rst_n & (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  // Clears first, then the set, so a same-index set wins over a writeback clear.
  always_comb begin
    busy_next = busy;
    if (wb_we) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (flush && out_valid && out_we) begin
      busy_next[out_rd] = 1'b0;
    end
    if (accept && dec_we) begin
      busy_next[rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc       <= '0;
      out_rs1_val  <= '0;
      out_rs2_val  <= '0;
      out_imm      <= 32'd0;
      out_rd       <= 5'd0;
      out_opcode   <= 7'd0;
      out_funct3   <= 3'd0;
      out_funct7b5 <= 1'b0;
      out_we       <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (accept) begin
      out_pc       <= in_pc;
      out_rs1_val  <= RD1;
      out_rs2_val  <= RD2;
      out_imm      <= dec_imm;
      out_rd       <= rd;
      out_opcode   <= opcode;
      out_funct3   <= funct3;
      out_funct7b5 <= in_instr[30];
      out_we       <= dec_we;
      out_illegal  <= dec_illegal;
    end
  end

`ifdef DECODE_STALL_COUNT_EN
  // Counts cycles where a presented instruction is held back by the scoreboard.
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if (in_valid && hazard) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode formats, scoreboard stalls,
// backpressure, flush and illegal/x0 cases against hand-computed values.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_we;
  logic        out_illegal;
  logic [31:0] stall_count;

  int tests_run;
  int tests_failed;

`ifdef DECODE_STALL_COUNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd3;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

  decode_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .A1           (A1),
    .A2           (A2),
    .RD1          (RD1),
    .RD2          (RD2),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_val  (out_rs1_val),
    .out_rs2_val  (out_rs2_val),
    .out_imm      (out_imm),
    .out_rd       (out_rd),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_we       (out_we),
    .out_illegal  (out_illegal),
    .stall_count  (stall_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 reads 0, xN reads 0x1000 + N.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    rf_val = (a == 5'd0) ? 32'd0 : (32'h1000 + {27'd0, a});
  endfunction

  assign RD1 = rf_val(A1);
  assign RD2 = rf_val(A2);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    flush     = 1'b1;
    wb_we     = 1'b0;
    wb_rd     = 5'd0;
    out_ready = 1'b0;
    drive(1'b1, 32'h00700293, 32'h0000_0100);

    // Reset, with flush and in_valid also asserted
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_imm", out_imm, 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_rd_we_ill", {out_rd, out_we, out_illegal}, 32'd0);
    check_eq("rst_stall_count", stall_count, 32'd0);
    check_eq("rst_busy", dut.busy, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    #1;

    // addi x5,x0,7
    check_eq("addi_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("addi_A1", {27'd0, A1}, 32'd0);
    step();
    check_eq("addi_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_out_imm", out_imm, 32'd7);
    check_eq("addi_out_rd", {27'd0, out_rd}, 32'd5);
    check_eq("addi_out_we", {31'd0, out_we}, 32'd1);
    check_eq("addi_out_pc", out_pc, 32'h0000_0100);
    check_eq("addi_opcode", {25'd0, out_opcode}, 32'h13);
    check_eq("addi_rs1_val", out_rs1_val, 32'd0);
    check_eq("addi_busy", dut.busy, 32'h0000_0020);

    // add x6,x5,x5 stalls on busy x5 until it retires
    drive(1'b1, 32'h00528333, 32'h0000_0104);
    out_ready = 1'b1;
    #1;
    check_eq("add_stall_c0", {31'd0, in_ready}, 32'd0);
    step();
    check_eq("add_drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("add_stall_c1", {31'd0, in_ready}, 32'd0);
    step();
    wb_we = 1'b1;
    wb_rd = 5'd5;
    #1;
    check_eq("add_stall_retire_cyc", {31'd0, in_ready}, 32'd0);
    step();
    wb_we = 1'b0;
    #1;
    check_eq("add_ready_after_retire", {31'd0, in_ready}, 32'd1);
    check_eq("add_stall_count", stall_count, EXP_STALLS);
    step();
    check_eq("add_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("add_out_rd", {27'd0, out_rd}, 32'd6);
    check_eq("add_rs1_val", out_rs1_val, 32'h0000_1005);
    check_eq("add_rs2_val", out_rs2_val, 32'h0000_1005);
    check_eq("add_out_imm", out_imm, 32'd0);
    check_eq("add_busy", dut.busy, 32'h0000_0040);

    // beq x1,x2,-4 with x6 retiring in the same cycle
    drive(1'b1, 32'hFE208EE3, 32'h0000_0108);
    wb_we = 1'b1;
    wb_rd = 5'd6;
    #1;
    check_eq("beq_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    wb_we = 1'b0;
    check_eq("beq_out_imm", out_imm, 32'hFFFF_FFFC);
    check_eq("beq_out_we", {31'd0, out_we}, 32'd0);
    check_eq("beq_rs_vals", out_rs1_val ^ out_rs2_val, 32'h0000_1001 ^ 32'h0000_1002);
    check_eq("beq_opcode", {25'd0, out_opcode}, 32'h63);
    check_eq("beq_busy", dut.busy, 32'd0);
    check_eq("stall_count_kept", stall_count, EXP_STALLS);

    // Backpressure: lui x7,0x12345 waits behind the held beq
    drive(1'b1, 32'h123453B7, 32'h0000_010C);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check_eq("bp_hold_imm", out_imm, 32'hFFFF_FFFC);
      check_eq("bp_hold_pc", out_pc, 32'h0000_0108);
      check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("lui_out_imm", out_imm, 32'h1234_5000);
    check_eq("lui_out_rd", {27'd0, out_rd}, 32'd7);
    check_eq("lui_busy", dut.busy, 32'h0000_0080);

    // Flush the held lui
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    flush     = 1'b1;
    #1;
    check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_busy", dut.busy, 32'd0);

    // Illegal opcode 0x7F with rd=3
    out_ready = 1'b1;
    drive(1'b1, 32'h000001FF, 32'h0000_0200);
    step();
    check_eq("ill_out_illegal", {31'd0, out_illegal}, 32'd1);
    check_eq("ill_out_we", {31'd0, out_we}, 32'd0);
    check_eq("ill_out_imm", out_imm, 32'd0);
    check_eq("ill_busy", dut.busy, 32'd0);

    // addi x0,x0,5: write to x0 is dropped
    drive(1'b1, 32'h00500013, 32'h0000_0204);
    step();
    check_eq("x0_out_we", {31'd0, out_we}, 32'd0);
    check_eq("x0_out_illegal", {31'd0, out_illegal}, 32'd0);
    check_eq("x0_out_imm", out_imm, 32'd5);
    check_eq("x0_busy", dut.busy, 32'd0);

    // addi x10,x0,1 while x10 retires: set wins
    drive(1'b1, 32'h00100513, 32'h0000_0208);
    wb_we = 1'b1;
    wb_rd = 5'd10;
    step();
    wb_we = 1'b0;
    check_eq("setwins_busy", dut.busy, 32'h0000_0400);

    // sw x2,8(x1)
    drive(1'b1, 32'h0020A423, 32'h0000_020C);
    step();
    check_eq("sw_out_imm", out_imm, 32'd8);
    check_eq("sw_out_we", {31'd0, out_we}, 32'd0);
    check_eq("sw_funct3", {29'd0, out_funct3}, 32'd2);

    // jal x1,-8
    drive(1'b1, 32'hFF9FF0EF, 32'h0000_0210);
    step();
    check_eq("jal_out_imm", out_imm, 32'hFFFF_FFF8);
    check_eq("jal_out_we_rd", {26'd0, out_we, out_rd}, {26'd0, 1'b1, 5'd1});
    check_eq("jal_busy", dut.busy, 32'h0000_0402);

    drive(1'b0, 32'h0, 32'h0);
    step();
    check_eq("final_drain_valid", {31'd0, out_valid}, 32'd0);

    // Report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1, in_instr in 32, in_pc in 32: fetch handshake, instruction and its PC.
REQ-005 SHALL have ports A1 out 5, A2 out 5 (register-file read addresses) and RD1 in 32, RD2 in 32 (combinational read data).
REQ-006 SHALL have ports wb_we in 1, wb_rd in 5: writeback retire, same cycle as register-file write (WE3/A3).
REQ-007 SHALL have port flush in 1: discard held instruction.
REQ-008 SHALL have ports out_valid out 1, out_ready in 1, out_pc out 32, out_rs1_val out 32, out_rs2_val out 32, out_imm out 32, out_rd out 5, out_opcode out 7, out_funct3 out 3, out_funct7b5 out 1, out_we out 1, out_illegal out 1.
REQ-009 SHALL have port stall_count out 32 (see Configuration).

Function
REQ-010 SHALL drive A1=in_instr[19:15], A2=in_instr[24:20] combinationally.
REQ-011 SHALL classify opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other opcode is illegal (no reads, no write, out_illegal=1).
REQ-012 SHALL treat rs1 as used for R, I-ALU, LOAD, STORE, BRANCH, JALR; rs2 as used for R, STORE, BRANCH; rd as written (we) for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC when rd!=0.
REQ-013 SHALL form out_imm sign-extended per RV32I I/S/B/U/J formats; B and J immediates have bit0=0; R and illegal give 0.
REQ-014 SHALL keep a 32-bit busy scoreboard; busy[0] is constant 0.
REQ-015 SHALL assert hazard when a used rs1/rs2 is busy, or when we=1 and busy[rd] (WAW).
REQ-016 SHALL drive in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-017 SHALL, on in_valid&in_ready, load all out_* registers in one cycle (latency 1), capture RD1/RD2, set out_valid=1, set busy[rd] if we.
REQ-018 SHALL clear out_valid on out_valid&out_ready without new accept; out_* hold while out_valid&!out_ready.
REQ-019 SHALL clear busy[wb_rd] on wb_we; same-cycle set and clear of the same index: set wins.
REQ-020 SHALL use the pre-clear busy vector for hazard (no bypass); a source retiring this cycle is read next cycle.
REQ-021 SHALL, on flush, clear out_valid and clear busy[out_rd] if out_valid&out_we; flush blocks accept that cycle; wb clears still apply.

Reset
REQ-022 SHALL, on rst_n=0, immediately clear out_valid, busy vector, stall_count and all out_* registers to 0, regardless of clock.
REQ-023 SHALL drive in_ready=0 while rst_n=0; first accept is possible on the first rising edge after deassertion.

Configuration
REQ-024 SHALL, with macro DECODE_STALL_COUNT_EN defined, increment stall_count (wrapping at 2^32) each cycle with in_valid=1 and hazard=1.
REQ-025 SHALL, without DECODE_STALL_COUNT_EN, tie stall_count to 0 and instantiate no counter.

Verification
REQ-026 Accept addi x5,x0,7 (0x00700293), RD1=0 -> next cycle out_valid=1, out_imm=7, out_rd=5, out_we=1, busy[5]=1.
REQ-027 Then add x6,x5,x5 with no retire -> in_ready=0 held; wb_we=1,wb_rd=5 -> accepted the following cycle; stall_count=number of stalled cycles when DECODE_STALL_COUNT_EN is defined, else 0.
REQ-028 beq x1,x2,-4 (0xFE208EE3) -> out_imm=0xFFFFFFFC, out_we=0, no busy bit set.
REQ-029 out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instruction loads same edge.
REQ-030 flush while holding lui x7 -> out_valid=0, busy[7]=0 next cycle; flush during reset -> all outputs 0.
REQ-031 Opcode 0x7F, or rd=x0 write -> out_illegal=1 or out_we=0 respectively, busy unchanged.
